tv_pixel_shift: RTL and testbench

- Video pixel stage directly downstream of the TV sync/timing generator.
- Consumes the generator's beam counters, pixel-tick pulse and composite sync.
- Fetches a 256x192 1-bpp bitmap from video RAM one byte per 8 pixels, serialises it MSB-first, and mixes pixels, border and sync into a 2-bit composite level for the output DAC.

---
 rtl/tv_pkg.sv | 13 +
 rtl/tv_fetch_addr.sv | 49 ++++
 rtl/tv_pixel_shift.sv | 82 ++++++++
 tb/tb_tv_pixel_shift.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tv_pkg.sv
// Shared composite levels and screen geometry for the TV video path.
// Pure constants; no logic.
// Imported by the fetch decoder and the pixel shifter.
package tv_pkg;
    localparam logic [1:0] CV_SYNC  = 2'b00;
    localparam logic [1:0] CV_BLACK = 2'b01;
    localparam logic [1:0] CV_GREY  = 2'b10;
    localparam logic [1:0] CV_WHITE = 2'b11;

    localparam int SCR_W          = 256;
    localparam int SCR_H          = 192;
    localparam int BYTES_PER_LINE = 32;
endpackage

// File: rtl/tv_fetch_addr.sv
// Decodes the fetch window from the beam counters and issues VRAM byte reads.
// Latency: vram_rd/vram_addr registered one clk_in after the fetch tick; rd lasts one cycle.
// No backpressure: VRAM must answer exactly one cycle after vram_rd.
module tv_fetch_addr #(
    parameter int H_START = 96,
    parameter int V_START = 62,
    parameter int ADDR_W  = 13
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [8:0]        cntHS,
    input  logic [8:0]        cntVS,
    input  logic              pixel_clk,
    output logic              line_act,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr
);
    import tv_pkg::*;

    localparam logic [8:0] V_LO = 9'(V_START);
    localparam logic [8:0] V_HI = 9'(V_START + SCR_H - 1);
    localparam logic [8:0] F_LO = 9'(H_START - 8);
    localparam logic [8:0] F_HI = 9'(H_START + SCR_W - 16);

    logic [7:0]  y8;
    logic [4:0]  col;
    logic [12:0] addr_nxt;
    logic        fetch;

    // Fetch runs one byte ahead of the display, so column 0 is read at H_START-8.
    assign line_act = (cntVS >= V_LO) && (cntVS <= V_HI);
    assign y8       = 8'(cntVS - V_LO);
    assign col      = 5'((cntHS - F_LO) >> 3);
    assign addr_nxt = {y8, col};
    assign fetch    = pixel_clk && line_act && (cntHS[2:0] == 3'd0) &&
                      (cntHS >= F_LO) && (cntHS <= F_HI);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            vram_rd   <= 1'b0;
            vram_addr <= '0;
        end else begin
            vram_rd <= fetch;
            if (fetch) begin
                vram_addr <= ADDR_W'(addr_nxt);
            end
        end
    end
endmodule

// File: rtl/tv_pixel_shift.sv
// Serialises 1-bpp VRAM bytes MSB-first and mixes pixels, border and sync into composite.
// Latency: pixel x on composite from the tick at cntHS=H_START+x; byte fetched 8 ticks ahead.
// No backpressure: advances only on pixel_clk ticks, VRAM data is captured unconditionally.
module tv_pixel_shift #(
    parameter int H_START = 96,
    parameter int V_START = 62,
    parameter int ADDR_W  = 13
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [8:0]        cntHS,
    input  logic [8:0]        cntVS,
    input  logic              pixel_clk,
    input  logic              sync_in,
    input  logic              invert,
    input  logic              border_white,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [7:0]        vram_q,
    output logic [1:0]        composite
);
    import tv_pkg::*;

    localparam logic [8:0] H_LO = 9'(H_START);
    localparam logic [8:0] H_HI = 9'(H_START + SCR_W - 1);

    logic       line_act;
    logic       h_act;
    logic       active;
    logic       load;
    logic       pix;
    logic       rd_d;
    logic [7:0] hold;
    logic [7:0] shreg;

    tv_fetch_addr #(
        .H_START (H_START),
        .V_START (V_START),
        .ADDR_W  (ADDR_W)
    ) u_fetch (
        .clk_in    (clk_in),
        .rst       (rst),
        .cntHS     (cntHS),
        .cntVS     (cntVS),
        .pixel_clk (pixel_clk),
        .line_act  (line_act),
        .vram_rd   (vram_rd),
        .vram_addr (vram_addr)
    );

    assign h_act  = (cntHS >= H_LO) && (cntHS <= H_HI);
    assign active = line_act && h_act;
    assign load   = active && (cntHS[2:0] == 3'd0);
    // On a byte boundary the first pixel comes straight from hold, not the stale shifter.
    assign pix    = load ? hold[7] : shreg[6];

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            rd_d      <= 1'b0;
            hold      <= '0;
            shreg     <= '0;
            composite <= CV_SYNC;
        end else begin
            rd_d <= vram_rd;
            if (rd_d) begin
                hold <= vram_q;
            end
            if (pixel_clk) begin
                if (active) begin
                    shreg <= load ? hold : (shreg << 1);
                end
                if (!sync_in) begin
                    composite <= CV_SYNC;
                end else if (active) begin
                    composite <= (pix ^ invert) ? CV_WHITE : CV_BLACK;
                end else begin
                    composite <= border_white ? CV_GREY : CV_BLACK;
                end
            end
        end
    end
endmodule

// File: tb/tb_tv_pixel_shift.sv
// Directed + randomized bench for tv_pixel_shift against a pixel-level reference model.
module tb_tv_pixel_shift;
    import tv_pkg::*;

    localparam int H  = 96;
    localparam int V  = 62;
    localparam int AW = 13;

    logic          clk_in = 1'b0;
    logic          rst;
    logic [8:0]    cntHS;
    logic [8:0]    cntVS;
    logic          pixel_clk;
    logic          sync_in;
    logic          invert;
    logic          border_white;
    logic          vram_rd;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_q;
    logic [1:0]    composite;

    logic [7:0]    mem [0:8191];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            rd_total = 0;
    int            rd_outside = 0;

    logic [1:0]    obs_comp;
    logic          obs_rd;
    logic          obs_rd2;
    logic [AW-1:0] obs_addr;

    tv_pixel_shift #(
        .H_START (H),
        .V_START (V),
        .ADDR_W  (AW)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .cntHS        (cntHS),
        .cntVS        (cntVS),
        .pixel_clk    (pixel_clk),
        .sync_in      (sync_in),
        .invert       (invert),
        .border_white (border_white),
        .vram_rd      (vram_rd),
        .vram_addr    (vram_addr),
        .vram_q       (vram_q),
        .composite    (composite)
    );

    always #5 clk_in = ~clk_in;

    // VRAM model: data one cycle after the strobe, junk at every other time.
    always @(posedge clk_in) begin
        if (vram_rd) begin
            vram_q   <= mem[vram_addr];
            rd_total <= rd_total + 1;
            if (cntVS < 9'(V) || cntVS > 9'(V + 191)) begin
                rd_outside <= rd_outside + 1;
            end
        end else begin
            vram_q <= 8'($urandom);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s hs=%0d vs=%0d: observed %0h, expected %0h", tag, cntHS, cntVS, obs, exp);
        end
    endtask

    function automatic logic line_in(input int vs);
        return (vs >= V) && (vs <= V + 191);
    endfunction

    // Expected level straight from the screen rules: bitmap bit at (x,y), border or sync.
    function automatic logic [1:0] ref_comp(input int hs, input int vs, input logic s,
                                            input logic inv, input logic bw);
        int         x;
        logic [7:0] b;
        if (!s) return CV_SYNC;
        if (line_in(vs) && hs >= H && hs <= H + 255) begin
            x = hs - H;
            b = mem[(vs - V) * 32 + x / 8];
            return (b[7 - x % 8] ^ inv) ? CV_WHITE : CV_BLACK;
        end
        return bw ? CV_GREY : CV_BLACK;
    endfunction

    // One pixel tick followed by one idle clk_in cycle.
    task automatic tick(input int hs, input int vs);
        cntHS     = 9'(hs);
        cntVS     = 9'(vs);
        pixel_clk = 1'b1;
        @(posedge clk_in); #1;
        pixel_clk = 1'b0;
        obs_comp  = composite;
        obs_rd    = vram_rd;
        obs_addr  = vram_addr;
        @(posedge clk_in); #1;
        obs_rd2   = vram_rd;
    endtask

    task automatic sweep_tick(input int hs, input int vs, input logic check_pix);
        logic er;
        tick(hs, vs);
        er = line_in(vs) && (hs % 8 == 0) && hs >= H - 8 && hs <= H + 240;
        chk("fetch_rd", 16'(obs_rd), 16'(er));
        if (er) chk("fetch_addr", 16'(obs_addr), 16'((vs - V) * 32 + (hs - H + 8) / 8));
        if (check_pix) chk("pixel", 16'(obs_comp), 16'(ref_comp(hs, vs, sync_in, invert, border_white)));
    endtask

    logic [1:0] ser_exp [8];
    int         rnd_line;
    int         rd0;
    int         out0;
    logic       full;

    initial begin
        ser_exp = '{CV_WHITE, CV_BLACK, CV_WHITE, CV_BLACK, CV_BLACK, CV_WHITE, CV_BLACK, CV_WHITE};
        rst = 1'b0; pixel_clk = 1'b0; sync_in = 1'b1; invert = 1'b0; border_white = 1'b0;
        cntHS = '0; cntVS = '0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        repeat (2) @(posedge clk_in);
        #1;

        // Reset with ticks running
        tick(H - 8, V + 5);
        chk("rst_comp", 16'(obs_comp), 16'(CV_SYNC));
        chk("rst_rd", 16'(obs_rd), 16'd0);
        chk("rst_addr", 16'(obs_addr), 16'd0);
        rst = 1'b1;
        tick(0, 0);
        chk("idle_border_black", 16'(obs_comp), 16'(CV_BLACK));

        // Fetch addressing
        border_white = 1'b1;
        tick(H - 8, V + 5);
        chk("fetch0_rd", 16'(obs_rd), 16'd1);
        chk("fetch0_addr", 16'(obs_addr), 16'd160);
        chk("fetch0_rd_pulse", 16'(obs_rd2), 16'd0);
        chk("fetch0_border", 16'(obs_comp), 16'(CV_GREY));
        tick(H + 4, V + 5);
        chk("nofetch_misaligned", 16'(obs_rd), 16'd0);
        tick(H + 240, V + 5);
        chk("fetch31_rd", 16'(obs_rd), 16'd1);
        chk("fetch31_addr", 16'(obs_addr), 16'd191);
        tick(H + 248, V + 5);
        chk("fetch32_none", 16'(obs_rd), 16'd0);
        chk("fetch32_addr_hold", 16'(obs_addr), 16'd191);

        // Asynchronous reset mid-cycle
        rst = 1'b0; #1;
        chk("arst_comp", 16'(composite), 16'(CV_SYNC));
        chk("arst_rd", 16'(vram_rd), 16'd0);
        chk("arst_addr", 16'(vram_addr), 16'd0);
        #1 rst = 1'b1;
        border_white = 1'b0;

        // Serialisation of 8'hA5, normal then inverted
        mem[0] = 8'hA5;
        for (int inv = 0; inv < 2; inv++) begin
            invert = 1'(inv);
            for (int hs = H - 8; hs < H + 8; hs++) begin
                tick(hs, V);
                if (hs >= H) chk("serial", 16'(obs_comp), 16'(inv != 0 ? (ser_exp[hs - H] ^ 2'b10) : ser_exp[hs - H]));
            end
        end
        invert = 1'b0;

        // Border above the picture, no reads
        border_white = 1'b1;
        for (int hs = H - 8; hs <= H + 16; hs += 4) begin
            tick(hs, V - 1);
            chk("border_grey", 16'(obs_comp), 16'(CV_GREY));
            chk("border_no_rd", 16'(obs_rd), 16'd0);
        end
        border_white = 1'b0;

        // Sync over a lit pixel
        for (int hs = H - 8; hs < H; hs++) tick(hs, V);
        sync_in = 1'b0;
        tick(H, V);
        chk("sync_dominates", 16'(obs_comp), 16'(CV_SYNC));
        sync_in = 1'b1;
        tick(H + 1, V);
        chk("after_sync", 16'(obs_comp), 16'(CV_BLACK));

        // Random line with random data, invert and sync drops
        rnd_line = V + $urandom_range(0, 191);
        invert   = 1'($urandom_range(0, 1));
        for (int hs = H - 16; hs < H + 264; hs++) begin
            sync_in = ($urandom_range(0, 15) != 0);
            sweep_tick(hs, rnd_line, 1'b1);
        end
        sync_in = 1'b1;
        invert  = 1'b0;

        // Mid-line reset; byte 3 of this line is blank so the group after reset is paper either way
        for (int c = 0; c < 32; c++) mem[10 * 32 + c] = 8'($urandom);
        mem[10 * 32 + 3] = 8'h00;
        for (int hs = H - 8; hs <= H + 20; hs++) sweep_tick(hs, V + 10, 1'b1);
        rst = 1'b0; #1;
        chk("midrst_comp", 16'(composite), 16'(CV_SYNC));
        #1 rst = 1'b1;
        for (int hs = H + 21; hs < H + 24; hs++) begin
            tick(hs, V + 10);
            chk("midrst_paper", 16'(obs_comp), 16'(CV_BLACK));
        end
        for (int hs = H + 24; hs < H + 48; hs++) sweep_tick(hs, V + 10, 1'b1);

        // Frame sweep over a checker bitmap
        for (int a = 0; a < 6144; a++) mem[a] = ((a >> 5) % 2 != 0) ? 8'h55 : 8'hAA;
        rnd_line = V + $urandom_range(2, 190);
        rd0  = rd_total;
        out0 = rd_outside;
        for (int vs = 0; vs < 311; vs++) begin
            invert       = 1'($urandom_range(0, 1));
            border_white = 1'($urandom_range(0, 1));
            full = (vs == V - 1) || (vs == V) || (vs == V + 1) || (vs == V + 95) ||
                   (vs == V + 191) || (vs == V + 192) || (vs == rnd_line);
            if (full) begin
                for (int hs = H - 16; hs < H + 264; hs++) begin
                    sync_in = ($urandom_range(0, 15) != 0);
                    sweep_tick(hs, vs, 1'b1);
                end
            end else begin
                sync_in = 1'b1;
                for (int hs = H - 8; hs <= H + 248; hs += 8) sweep_tick(hs, vs, 1'b0);
            end
        end
        sync_in = 1'b1;
        tick(0, 0);
        chk("wrap_no_rd", 16'(obs_rd), 16'd0);
        chk("frame_reads", 16'(rd_total - rd0), 16'd6144);
        chk("reads_outside_lines", 16'(rd_outside - out0), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
